// File: rtl/grant_decoder38.sv
// Registered one-hot grant decoder fed by the 8:3 priority encoder.
// Holds a grant until the grantee releases it or the hold limit expires, then inserts a dead-time gap.
module grant_decoder38 #(
    parameter int N_OUT    = 8,
    parameter int MAX_HOLD = 15,
    parameter int GAP      = 1,
    localparam int CODE_W  = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code,
    input  logic              idle,
    // "release" is a reserved word, hence the longer name.
    input  logic [N_OUT-1:0]  release_line,
    output logic [N_OUT-1:0]  grant,
    output logic [CODE_W-1:0] grant_code,
    output logic              busy,
    output logic              timeout,
    output logic [1:0]        fsm_state
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int GAP_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              state, state_n, after_release;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_n;
    logic [N_OUT-1:0]    grant_n;
    logic [CODE_W-1:0]   grant_code_n;
    logic                busy_n, timeout_n;
    logic                req_ok, rel_hit, hold_done;

    assign after_release = (GAP == 0) ? S_IDLE : S_GAP;
    assign req_ok        = !idle && (int'(code) < N_OUT);
    assign rel_hit       = release_line[grant_code];
    assign hold_done     = (hold_cnt == HOLD_W'(MAX_HOLD));
    assign fsm_state     = state;

    always_comb begin
        state_n      = state;
        hold_cnt_n   = hold_cnt;
        gap_cnt_n    = gap_cnt;
        grant_n      = grant;
        grant_code_n = grant_code;
        busy_n       = busy;
        timeout_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_ok) begin
                    grant_n      = N_OUT'(1) << code;
                    grant_code_n = code;
                    busy_n       = 1'b1;
                    hold_cnt_n   = HOLD_W'(1);
                    state_n      = S_GRANT;
                end
            end
            S_GRANT: begin
                // Release takes priority, so a release in the last hold cycle never pulses timeout.
                if (rel_hit || hold_done) begin
                    grant_n    = '0;
                    timeout_n  = !rel_hit;
                    busy_n     = (GAP != 0);
                    hold_cnt_n = '0;
                    gap_cnt_n  = GAP_W'(1);
                    state_n    = after_release;
                end else begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP)) begin
                    busy_n    = 1'b0;
                    gap_cnt_n = '0;
                    state_n   = S_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                grant_n = '0;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            grant      <= '0;
            grant_code <= '0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_cnt_n;
            gap_cnt    <= gap_cnt_n;
            grant      <= grant_n;
            grant_code <= grant_code_n;
            busy       <= busy_n;
            timeout    <= timeout_n;
        end
    end

endmodule
